ps2_key_state: RTL
==================

PS2_KEY_STATE -- requirements
Module: ps2_key_state

Interface
REQ-001 SHALL have parameter FILTER_LEN, default 4: consecutive equal synchronised samples required to accept a ps2_clk level change.
REQ-002 SHALL have parameter TIMEOUT_CYCLES, default 50000: idle clk cycles after which a partial frame is discarded.
REQ-003 SHALL have port clk, input, 1: system clock; one clock domain only.
REQ-004 SHALL have port rst_n, input, 1: reset, asynchronous assertion, active-low.
REQ-005 SHALL have port ps2_clk, input, 1: PS/2 device clock, asynchronous to clk.
REQ-006 SHALL have port ps2_data, input, 1: PS/2 device data, asynchronous to clk.
REQ-007 SHALL have port key_state, output, 5: held-key vector; bit0 left, bit1 up, bit2 right, bit3 down, bit4 jump; feeds the movement key processor directly.
REQ-008 SHALL have port scan_code, output, 8: last correctly received byte.
REQ-009 SHALL have port code_valid, output, 1: one-cycle pulse when scan_code is updated.
REQ-010 SHALL have port frame_err, output, 1: one-cycle pulse on a parity error, stop-bit error or timeout.

Function
REQ-011 SHALL pass ps2_clk and ps2_data through two-flop synchronisers before any other use.
REQ-012 SHALL accept a ps2_clk falling edge only after FILTER_LEN consecutive low samples following an accepted high level.
REQ-013 SHALL sample ps2_data on each accepted falling edge; frame = start(0), 8 data bits LSB first, odd parity, stop(1).
REQ-014 SHALL abort a frame whose start bit samples as 1 without pulsing frame_err, and wait for the next falling edge.
REQ-015 SHALL pulse frame_err and discard the byte on a parity or stop-bit failure.
REQ-016 SHALL discard a partial frame with no accepted edge for TIMEOUT_CYCLES cycles, pulse frame_err once, and restart at the start bit.
REQ-017 SHALL update scan_code and pulse code_valid in the cycle after the stop-bit edge is accepted.
REQ-018 SHALL run a decoder FSM on each code_valid; states IDLE, EXT, BRK and EXT_BRK.
REQ-019 In IDLE, the decoder SHALL go to EXT on E0 and to BRK on F0; on 29 it SHALL set bit4 and stay in IDLE.
REQ-020 In EXT, the decoder SHALL go to EXT_BRK on F0; on 6B/75/74/72 it SHALL set bit0/1/2/3 and go to IDLE.
REQ-021 In BRK, the decoder SHALL clear bit4 on 29 and go to IDLE.
REQ-022 In EXT_BRK, the decoder SHALL clear bit0/1/2/3 on 6B/75/74/72 and go to IDLE.
REQ-023 Any other byte in any state SHALL return the decoder to IDLE with key_state unchanged; E0 received in BRK or EXT_BRK SHALL go to EXT.
REQ-024 Non-extended 6B/75/74/72 and extended E0 29 SHALL NOT change key_state.
REQ-025 A repeated make code (typematic) SHALL leave an already-set bit set, with no glitch.
REQ-026 A frame_err pulse SHALL force the decoder to IDLE with key_state unchanged.
REQ-027 key_state SHALL be registered and change in the cycle after the decoding code_valid.
REQ-028 Multiple bits of key_state SHALL be allowed to be set at once; prioritising them is the consumer's job.

Reset
REQ-029 While rst_n=0: key_state=0, scan_code=00, code_valid=0, frame_err=0, decoder IDLE, bit counter 0, timeout counter 0, synchronisers and filter preset to idle-high.
REQ-030 Reset asserted mid-frame SHALL drop the frame; after release, reception SHALL resume at the next start bit with no error pulse.

Structure
REQ-031 The shared package SHALL hold the scan-code constants (E0, F0, 6B, 75, 74, 72, 29), the key_state bit indices and the decoder state enumeration.
REQ-032 Frame reception (sync, filter, shift, parity, timeout) SHALL be sub-module ps2_rx; ps2_key_state SHALL instantiate it and hold the decoder FSM.

Verification
REQ-033 Frames E0, 75 -> key_state=00010; then E0, F0, 75 -> key_state=00000.
REQ-034 29; E0 6B; E0 74 -> key_state=10101; then F0 29 -> key_state=00101.
REQ-035 Byte 29 sent with even parity -> frame_err pulses once, code_valid=0, key_state unchanged.
REQ-036 Stop after bit 4 for TIMEOUT_CYCLES+1 cycles -> one frame_err pulse; next full frame 29 -> key_state[4]=1.
REQ-037 Non-extended 6B, then E0 29 -> key_state stays 00000; code_valid pulses once per byte (three times).
REQ-038 1-cycle ps2_clk low glitches mid-frame -> no extra bits counted; rst_n low mid-frame, then frame 29 -> key_state=10000 with no frame_err.

Source files
------------

// File: rtl/ps2_key_state_pkg.sv
// Shared scan-code constants, key_state bit layout and decoder states for the
// PS/2 movement-key front end.
package ps2_key_state_pkg;

  localparam logic [7:0] SC_EXT   = 8'hE0;
  localparam logic [7:0] SC_BRK   = 8'hF0;
  localparam logic [7:0] SC_LEFT  = 8'h6B;
  localparam logic [7:0] SC_UP    = 8'h75;
  localparam logic [7:0] SC_RIGHT = 8'h74;
  localparam logic [7:0] SC_DOWN  = 8'h72;
  localparam logic [7:0] SC_JUMP  = 8'h29;

  localparam int unsigned KEY_LEFT  = 0;
  localparam int unsigned KEY_UP    = 1;
  localparam int unsigned KEY_RIGHT = 2;
  localparam int unsigned KEY_DOWN  = 3;
  localparam int unsigned KEY_JUMP  = 4;

  typedef enum logic [1:0] {IDLE, EXT, BRK, EXT_BRK} dec_state_t;

  // One-hot key_state mask for an extended arrow code, zero for anything else.
  function automatic logic [4:0] arrow_mask(input logic [7:0] code);
    logic [4:0] m;
    m = '0;
    case (code)
      SC_LEFT:  m[KEY_LEFT]  = 1'b1;
      SC_UP:    m[KEY_UP]    = 1'b1;
      SC_RIGHT: m[KEY_RIGHT] = 1'b1;
      SC_DOWN:  m[KEY_DOWN]  = 1'b1;
      default:  m = '0;
    endcase
    return m;
  endfunction

endpackage

// File: rtl/ps2_rx.sv
// PS/2 frame receiver: synchronise, glitch-filter ps2_clk, shift in
// start/8 data/odd parity/stop, and drop stalled frames after a timeout.
module ps2_rx #(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  localparam int unsigned FW = (FILTER_LEN > 1) ? $clog2(FILTER_LEN) : 1;
  localparam int unsigned TW = $clog2(TIMEOUT_CYCLES + 1);

  logic [1:0]    clk_sync, data_sync;
  logic          clk_filt;
  logic [FW-1:0] flt_cnt;
  logic          flip, fall, in_frame, timeout, din;
  logic [3:0]    bit_cnt;
  logic [7:0]    shreg;
  logic          parity;
  logic [TW-1:0] to_cnt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_sync  <= 2'b11;
      data_sync <= 2'b11;
    end else begin
      clk_sync  <= {clk_sync[0], ps2_clk};
      data_sync <= {data_sync[0], ps2_data};
    end
  end

  assign din = data_sync[1];

  // The filtered level flips on the FILTER_LEN-th consecutive differing
  // sample; the falling edge is reported in that same cycle.
  assign flip = (clk_sync[1] != clk_filt) && (flt_cnt == FW'(FILTER_LEN - 1));
  assign fall = flip && clk_filt;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      clk_filt <= 1'b1;
      flt_cnt  <= '0;
    end else if (clk_sync[1] == clk_filt) begin
      flt_cnt  <= '0;
    end else if (flip) begin
      clk_filt <= ~clk_filt;
      flt_cnt  <= '0;
    end else begin
      flt_cnt  <= flt_cnt + 1'b1;
    end
  end

  assign in_frame = (bit_cnt != 4'd0);
  assign timeout  = in_frame && !fall && (to_cnt == TW'(TIMEOUT_CYCLES - 1));

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      bit_cnt    <= 4'd0;
      shreg      <= '0;
      parity     <= 1'b0;
      to_cnt     <= '0;
      scan_code  <= '0;
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
    end else begin
      code_valid <= 1'b0;
      frame_err  <= 1'b0;
      if (!in_frame || fall) to_cnt <= '0;
      else                   to_cnt <= to_cnt + 1'b1;

      if (timeout) begin
        bit_cnt   <= 4'd0;
        frame_err <= 1'b1;
      end else if (fall) begin
        case (bit_cnt)
          4'd0: if (!din) bit_cnt <= 4'd1;
          4'd9: begin
            parity  <= din;
            bit_cnt <= 4'd10;
          end
          4'd10: begin
            bit_cnt <= 4'd0;
            if (din && (^{shreg, parity})) begin
              scan_code  <= shreg;
              code_valid <= 1'b1;
            end else begin
              frame_err  <= 1'b1;
            end
          end
          default: begin
            shreg   <= {din, shreg[7:1]};
            bit_cnt <= bit_cnt + 4'd1;
          end
        endcase
      end
    end
  end

endmodule

// File: rtl/ps2_key_state.sv
// PS/2 keyboard to held-key vector: frame receiver plus make/break decoder
// tracking arrows (extended) and jump (29).
module ps2_key_state
  import ps2_key_state_pkg::*;
#(
  parameter int unsigned FILTER_LEN     = 4,
  parameter int unsigned TIMEOUT_CYCLES = 50000
) (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       ps2_clk,
  input  logic       ps2_data,
  output logic [4:0] key_state,
  output logic [7:0] scan_code,
  output logic       code_valid,
  output logic       frame_err
);

  dec_state_t state, state_n;
  logic [4:0] keys_n, mask;

  ps2_rx #(
    .FILTER_LEN    (FILTER_LEN),
    .TIMEOUT_CYCLES(TIMEOUT_CYCLES)
  ) u_rx (
    .clk       (clk),
    .rst_n     (rst_n),
    .ps2_clk   (ps2_clk),
    .ps2_data  (ps2_data),
    .scan_code (scan_code),
    .code_valid(code_valid),
    .frame_err (frame_err)
  );

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state     <= IDLE;
      key_state <= '0;
    end else begin
      state     <= state_n;
      key_state <= keys_n;
    end
  end

  always_comb begin
    state_n = state;
    keys_n  = key_state;
    mask    = arrow_mask(scan_code);
    if (frame_err) begin
      state_n = IDLE;
    end else if (code_valid) begin
      state_n = IDLE;
      case (state)
        IDLE: begin
          if (scan_code == SC_EXT)       state_n = EXT;
          else if (scan_code == SC_BRK)  state_n = BRK;
          else if (scan_code == SC_JUMP) keys_n[KEY_JUMP] = 1'b1;
        end
        EXT: begin
          if (scan_code == SC_BRK) state_n = EXT_BRK;
          else                     keys_n = key_state | mask;
        end
        BRK: begin
          if (scan_code == SC_EXT)       state_n = EXT;
          else if (scan_code == SC_JUMP) keys_n[KEY_JUMP] = 1'b0;
        end
        EXT_BRK: begin
          if (scan_code == SC_EXT) state_n = EXT;
          else                     keys_n = key_state & ~mask;
        end
        default: state_n = IDLE;
      endcase
    end
  end

endmodule
